// File: rtl/conv_window_scheduler.sv
// Walks (filter, output row, output column) in raster order, issues one window request per
// output pixel to the shared convolution unit and writes the in-order results to the output buffer.
module conv_window_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 1,
    parameter int H          = 4,
    parameter int W          = 4,
    parameter int F          = 2,
    parameter int K          = 1,
    parameter int MAX_OUT    = 2,
    localparam int OH        = H - F + 1,
    localparam int OW        = W - F + 1,
    localparam int N         = K * OH * OW,
    localparam int KW        = (K  > 1) ? $clog2(K)  : 1,
    localparam int RW        = (OH > 1) ? $clog2(OH) : 1,
    localparam int CW        = (OW > 1) ? $clog2(OW) : 1,
    localparam int AW        = (N  > 1) ? $clog2(N)  : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [KW-1:0]         req_k,
    output logic [RW-1:0]         req_row,
    output logic [CW-1:0]         req_col,
    input  logic                  res_valid,
    input  logic [DATA_WIDTH-1:0] res_data,
    output logic                  wr_en,
    output logic [AW-1:0]         wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data
);

    // state  | meaning
    // IDLE   | waiting for start
    // ISSUE  | issuing window requests, bounded by MAX_OUT in flight
    // DRAIN  | all requests issued, collecting remaining results
    // FINISH | one-cycle done pulse
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    localparam int OCW = $clog2(MAX_OUT + 1);

    // D is carried as layer metadata only; it takes no part in sequencing.
    if (D < 1 || F > H || F > W || K < 1 || MAX_OUT < 1) begin : g_param_check
        $error("conv_window_scheduler: illegal parameter set");
    end

    state_t                  state_q, state_d;
    logic [KW-1:0]           k_q, k_d;
    logic [RW-1:0]           row_q, row_d;
    logic [CW-1:0]           col_q, col_d;
    logic [OCW-1:0]          outst_q, outst_d;
    logic [AW-1:0]           wcnt_q, wcnt_d;
    logic                    err_q, err_d;
    logic                    wr_en_q, wr_en_d;
    logic [AW-1:0]           wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;

    logic req_fire;
    logic res_acc;
    logic last_pos;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        row_d     = row_q;
        col_d     = col_q;
        outst_d   = outst_q;
        wcnt_d    = wcnt_q;
        err_d     = err_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        req_valid = (state_q == ISSUE) && (outst_q < OCW'(MAX_OUT));
        req_fire  = req_valid && req_ready;
        res_acc   = res_valid && (outst_q != '0);
        last_pos  = (k_q == KW'(K - 1)) && (row_q == RW'(OH - 1)) && (col_q == CW'(OW - 1));

        if (res_acc) begin
            wr_en_d   = 1'b1;
            wr_addr_d = wcnt_q;
            wr_data_d = res_data;
            wcnt_d    = wcnt_q + AW'(1);
        end

        if (req_fire && !res_acc) begin
            outst_d = outst_q + OCW'(1);
        end else if (!req_fire && res_acc) begin
            outst_d = outst_q - OCW'(1);
        end

        // Counters return to zero after the last position so the fields idle at 0.
        if (req_fire) begin
            if (col_q == CW'(OW - 1)) begin
                col_d = '0;
                if (row_q == RW'(OH - 1)) begin
                    row_d = '0;
                    k_d   = last_pos ? '0 : k_q + KW'(1);
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        if (state_q == IDLE && start) begin
            err_d = 1'b0;
        end
        if (res_valid && outst_q == '0) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    k_d     = '0;
                    row_d   = '0;
                    col_d   = '0;
                    outst_d = '0;
                    wcnt_d  = '0;
                end
            end
            ISSUE: begin
                if (req_fire && last_pos) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (res_acc && wcnt_q == AW'(N - 1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            k_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            outst_q   <= '0;
            wcnt_q    <= '0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            row_q     <= row_d;
            col_q     <= col_d;
            outst_q   <= outst_d;
            wcnt_q    <= wcnt_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == FINISH);
    assign err     = err_q;
    assign req_k   = k_q;
    assign req_row = row_q;
    assign req_col = col_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Self-checking bench for conv_window_scheduler: randomized ready/result timing against a
// transaction-level model of requests, outstanding count and output-buffer writes.
module tb_conv_window_scheduler;

    localparam int DW      = 16;
    localparam int H       = 4;
    localparam int W       = 5;
    localparam int F       = 2;
    localparam int K       = 2;
    localparam int MAX_OUT = 2;
    localparam int OH      = H - F + 1;
    localparam int OW      = W - F + 1;
    localparam int N       = K * OH * OW;
    localparam int KW      = (K  > 1) ? $clog2(K)  : 1;
    localparam int RW      = (OH > 1) ? $clog2(OH) : 1;
    localparam int CW      = (OW > 1) ? $clog2(OW) : 1;
    localparam int AW      = (N  > 1) ? $clog2(N)  : 1;

    logic          clk = 1'b0;
    logic          reset, start, req_ready, res_valid;
    logic [DW-1:0] res_data;
    logic          busy, done, err, req_valid, wr_en;
    logic [KW-1:0] req_k;
    logic [RW-1:0] req_row;
    logic [CW-1:0] req_col;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    always #5 clk = ~clk;

    conv_window_scheduler #(
        .DATA_WIDTH(DW), .D(1), .H(H), .W(W), .F(F), .K(K), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
        .req_valid(req_valid), .req_ready(req_ready), .req_k(req_k), .req_row(req_row),
        .req_col(req_col), .res_valid(res_valid), .res_data(res_data), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // stimulus controls
    bit g_start = 0, g_reset = 0, g_stray = 0, g_fixed = 0, g_lat_rand = 0;
    int g_rdy = 1;
    int g_lat = 1;

    // reference model: 0 idle, 1 running, 2 done pulse
    int          m_phase = 0;
    int          m_issued = 0;
    int          m_outst = 0;
    int          m_wcnt = 0;
    bit          m_err = 0;
    bit          m_wr = 0;
    int          m_addr = 0;
    logic [DW-1:0] m_data = '0;
    int          m_start_cyc = 0;
    int          pend[$];

    int obs_done_cyc = 0;
    int obs_done_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit            exp_rv, hs, acc;
        logic [DW-1:0] d;
        int            lat;
        exp_rv = (m_phase == 1) && (m_issued < N) && (m_outst < MAX_OUT);
        chk("req_valid", 32'(req_valid), 32'(exp_rv));
        if (exp_rv) begin
            chk("req_k",   32'(req_k),   32'(m_issued / (OH * OW)));
            chk("req_row", 32'(req_row), 32'((m_issued % (OH * OW)) / OW));
            chk("req_col", 32'(req_col), 32'(m_issued % OW));
        end
        chk("busy",  32'(busy),  32'(m_phase != 0));
        chk("done",  32'(done),  32'(m_phase == 2));
        chk("err",   32'(err),   32'(m_err));
        chk("wr_en", 32'(wr_en), 32'(m_wr));
        if (m_wr) begin
            chk("wr_addr", 32'(wr_addr), 32'(m_addr));
            chk("wr_data", 32'(wr_data), 32'(m_data));
        end
        if (done === 1'b1) begin
            obs_done_cyc = cyc;
            obs_done_cnt++;
        end

        start = g_start;
        reset = g_reset;
        case (g_rdy)
            0:       req_ready = 1'($urandom_range(0, 1));
            1:       req_ready = 1'b1;
            default: req_ready = ~req_ready;
        endcase
        res_valid = g_stray || (pend.size() > 0 && pend[0] <= cyc);
        d = g_fixed ? 16'h4400 : 16'($urandom);
        res_data = d;

        if (g_reset) begin
            m_phase = 0; m_issued = 0; m_outst = 0; m_wcnt = 0; m_err = 0; m_wr = 0;
            pend.delete();
        end else begin
            hs  = exp_rv && req_ready;
            acc = res_valid && (m_outst > 0);
            m_wr = acc;
            if (acc) begin
                m_addr = m_wcnt;
                m_data = d;
                m_wcnt++;
                if (pend.size() > 0) void'(pend.pop_front());
            end
            if (m_phase == 0 && start) m_err = 0;
            if (res_valid && m_outst == 0) m_err = 1;
            m_outst = m_outst + int'(hs) - int'(acc);
            if (hs) begin
                lat = g_lat_rand ? int'($urandom_range(1, g_lat)) : g_lat;
                pend.push_back(cyc + lat);
                m_issued++;
            end
            case (m_phase)
                0: if (start) begin
                    m_phase = 1; m_issued = 0; m_wcnt = 0; m_outst = 0; m_start_cyc = cyc;
                end
                1: if (acc && m_wcnt == N) m_phase = 2;
                default: m_phase = 0;
            endcase
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_pass(input bit check_len, input bit start_in_done,
                            input bit extra_starts, input int abort_hs);
        int t;
        t = 0;
        obs_done_cnt = 0;
        g_start = 1;
        cycle();
        g_start = 0;
        while (m_phase != 0 && t < 3000) begin
            if (abort_hs > 0 && m_issued >= abort_hs) break;
            g_start = (extra_starts && (t == 3 || t == 6)) || (start_in_done && m_phase == 2);
            cycle();
            g_start = 0;
            t++;
        end
        if (abort_hs == 0) begin
            chk("pass_done_count", 32'(obs_done_cnt), 32'd1);
            chk("pass_end_busy", 32'(busy), 32'd0);
            if (check_len) chk("pass_length", 32'(obs_done_cyc - m_start_cyc), 32'(N + 2));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; req_ready = 1'b0; res_valid = 1'b0; res_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_req_k", 32'(req_k), 32'd0);
        chk("rst_req_row", 32'(req_row), 32'd0);
        chk("rst_req_col", 32'(req_col), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);

        // stray result while idle
        g_stray = 1; cycle(); g_stray = 0; cycle();
        chk("idle_stray_err", 32'(err), 32'd1);
        chk("idle_stray_wr_en", 32'(wr_en), 32'd0);

        // zero-wait ready, 1-cycle results, constant data
        g_rdy = 1; g_lat = 1; g_lat_rand = 0; g_fixed = 1;
        run_pass(1'b1, 1'b0, 1'b0, 0);
        chk("pass_a_err", 32'(err), 32'd0);

        // toggling ready, random latency and data; start during done is ignored
        g_rdy = 2; g_lat = 3; g_lat_rand = 1; g_fixed = 0;
        run_pass(1'b0, 1'b1, 1'b0, 0);

        // start in the cycle after done; results held back 5 cycles; spurious starts mid-pass
        g_rdy = 0; g_lat = 5; g_lat_rand = 0;
        run_pass(1'b0, 1'b0, 1'b1, 0);

        // reset mid-pass after the 4th handshake
        g_rdy = 1; g_lat = 2; g_lat_rand = 0;
        run_pass(1'b0, 1'b0, 1'b0, 4);
        g_reset = 1; cycle(); g_reset = 0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_req_valid", 32'(req_valid), 32'd0);
        chk("mid_rst_req_col", 32'(req_col), 32'd0);
        chk("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("mid_rst_wr_data", 32'(wr_data), 32'd0);
        g_stray = 1; cycle(); cycle(); g_stray = 0; cycle();
        chk("late_res_err", 32'(err), 32'd1);
        chk("late_res_wr_en", 32'(wr_en), 32'd0);

        // clean pass after the error
        g_rdy = 0; g_lat = 4; g_lat_rand = 1;
        run_pass(1'b0, 1'b0, 1'b0, 0);
        chk("final_err", 32'(err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
